// File: rtl/image_stream_pkg.sv
// Shared types and constants for the image UART streamer.
package image_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        DONE
    } stream_state_t;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam logic        TX_IDLE        = 1'b1;

endpackage

// File: rtl/image_uart_streamer_uart_tx_serializer.sv
// 8N1 UART transmitter: start bit, eight data bits LSB-first, stop bit.
// A byte is accepted on load_i while idle; frame_done_o pulses in the last stop-bit cycle.
module uart_tx_serializer
    import image_stream_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       busy_o,
    output logic       bit_end_o,
    output logic       last_bit_o,
    output logic       frame_done_o,
    output logic       tx_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

    stream_state_t  phase_q, phase_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;

    assign bit_end_o    = (phase_q != IDLE) && (cnt_q == CntW'(CLKS_PER_BIT - 1));
    assign last_bit_o   = (bit_idx_q == 3'(UART_DATA_BITS - 1));
    assign frame_done_o = (phase_q == STOP_BIT) && bit_end_o;
    assign busy_o       = (phase_q != IDLE);
    assign tx_o         = tx_q;

    // Bit-period sequencing; tx_d follows the next phase so tx is aligned with the phase flop.
    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        unique case (phase_q)
            IDLE: begin
                tx_d = TX_IDLE;
                if (load_i) begin
                    phase_d = START_BIT;
                    shift_d = data_i;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            START_BIT: begin
                if (bit_end_o) begin
                    phase_d   = DATA_BITS;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            DATA_BITS: begin
                if (bit_end_o) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (last_bit_o) begin
                        phase_d = STOP_BIT;
                        tx_d    = TX_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            STOP_BIT: begin
                tx_d = TX_IDLE;
                if (bit_end_o) begin
                    phase_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                phase_d = IDLE;
                cnt_d   = '0;
                tx_d    = TX_IDLE;
            end
        endcase
    end

    // Serializer state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= TX_IDLE;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: rtl/image_uart_streamer.sv
// Streams NUM_BYTES bytes of the processed-image memory over a UART 8N1 line.
// The fetch FSM walks addresses 0..NUM_BYTES-1; uart_tx_serializer shapes each frame.
module image_uart_streamer
    import image_stream_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned NUM_BYTES    = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    stream_state_t     state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic ser_load;
    logic ser_busy;
    logic ser_bit_end;
    logic ser_last_bit;
    logic ser_frame_done;

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serializer (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (ser_load),
        .data_i      (rd_data),
        .busy_o      (ser_busy),
        .bit_end_o   (ser_bit_end),
        .last_bit_o  (ser_last_bit),
        .frame_done_o(ser_frame_done),
        .tx_o        (tx)
    );

    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;

    // Fetch FSM next state; the send states track the serializer's bit-period strobes.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ser_load  = 1'b0;
        unique case (state_q)
            IDLE: begin
                rd_addr_d = '0;
                busy_d    = 1'b0;
                if (start) begin
                    state_d = FETCH;
                    busy_d  = 1'b1;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                ser_load = !ser_busy;
                state_d  = START_BIT;
            end
            START_BIT: begin
                if (ser_bit_end) state_d = DATA_BITS;
            end
            DATA_BITS: begin
                if (ser_bit_end && ser_last_bit) state_d = STOP_BIT;
            end
            STOP_BIT: begin
                if (ser_frame_done) begin
                    if (rd_addr_q == ADDR_W'(NUM_BYTES - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        state_d   = FETCH;
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                rd_addr_d = '0;
            end
            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                rd_addr_d = '0;
            end
        endcase
    end

    // FSM and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_image_uart_streamer.sv
// Directed bench for image_uart_streamer; four instances cover the parameter sets.
// Expected bytes are queued when a run is started and popped frame by frame.
module tb_image_uart_streamer;

    logic        clk = 1'b0;
    logic        start_s [4];
    logic        rst_s   [4];
    logic        tx_w    [4];
    logic        busy_w  [4];
    logic        done_w  [4];
    logic [31:0] addr_w  [4];
    logic [7:0]  rdat    [4];
    logic [7:0]  mem     [4][4];

    logic [7:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Registered-read memories, one per instance.
    always @(posedge clk) begin
        rdat[0] <= mem[0][addr_w[0][1:0]];
        rdat[1] <= mem[1][addr_w[1][1:0]];
        rdat[2] <= mem[2][addr_w[2][1:0]];
        rdat[3] <= mem[3][addr_w[3][1:0]];
    end

    image_uart_streamer #(.CLKS_PER_BIT(4), .ADDR_W(32), .NUM_BYTES(1)) u_d0 (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .rd_addr(addr_w[0]),
        .rd_data(rdat[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    image_uart_streamer #(.CLKS_PER_BIT(4), .ADDR_W(32), .NUM_BYTES(3)) u_d1 (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .rd_addr(addr_w[1]),
        .rd_data(rdat[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    image_uart_streamer #(.CLKS_PER_BIT(4), .ADDR_W(32), .NUM_BYTES(2)) u_d2 (
        .clk(clk), .rst(rst_s[2]), .start(start_s[2]), .rd_addr(addr_w[2]),
        .rd_data(rdat[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
    image_uart_streamer #(.CLKS_PER_BIT(2), .ADDR_W(32), .NUM_BYTES(1)) u_d3 (
        .clk(clk), .rst(rst_s[3]), .start(start_s[3]), .rd_addr(addr_w[3]),
        .rd_data(rdat[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue a run's bytes and drive start so the next sample point is k=0 (first FETCH cycle).
    task automatic go(input int d, input int nb);
        for (int i = 0; i < nb; i++) exp_q.push_back(mem[d][i]);
        start_s[d] = 1'b1;
        step();
    endtask

    // Cycle-exact check of one run, called at k=0. Frame j occupies k in [j*p, (j+1)*p):
    // two idle-high cycles, then start, 8 data bits LSB-first and stop, cpb cycles each.
    task automatic run_check(input int d, input int cpb, input int nb, input int pulse_at,
                             input int abort_at, input bit hold, input string name);
        int p;
        int done_cnt;
        int done_k;
        logic [7:0] cur;
        logic [7:0] dec;
        bit wave_ok;
        bit addr_ok;
        bit busy_ok;
        p        = 10 * cpb + 2;
        done_cnt = 0;
        done_k   = -1;
        busy_ok  = 1'b1;
        wave_ok  = 1'b1;
        addr_ok  = 1'b1;
        cur      = 8'h00;
        dec      = 8'h00;
        for (int k = 0; k <= nb * p + 1; k++) begin
            int j;
            int off;
            int b;
            logic e;
            j   = k / p;
            off = k % p;
            if (k < nb * p) begin
                if (off == 0) begin
                    if (exp_q.size() > 0) cur = exp_q.pop_front();
                    dec     = 8'h00;
                    wave_ok = 1'b1;
                    addr_ok = 1'b1;
                end
                b = (off < 2) ? -1 : (off - 2) / cpb;
                if (b < 0 || b == 9) e = 1'b1;
                else if (b == 0)     e = 1'b0;
                else                 e = cur[b-1];
                if (tx_w[d] !== e) wave_ok = 1'b0;
                if (b >= 1 && b <= 8 && (off - 2) % cpb == cpb / 2) dec[b-1] = tx_w[d];
                if (addr_w[d] !== 32'(j)) addr_ok = 1'b0;
                if (busy_w[d] !== 1'b1) busy_ok = 1'b0;
                if (off == p - 1) begin
                    chk($sformatf("%s byte%0d", name, j), {24'h0, dec}, {24'h0, cur});
                    chk($sformatf("%s wave%0d", name, j), {31'h0, wave_ok}, 32'h1);
                    chk($sformatf("%s addr%0d", name, j), {31'h0, addr_ok}, 32'h1);
                end
            end else if (k == nb * p) begin
                chk({name, " busy_in_done"}, {31'h0, busy_w[d]}, 32'h1);
                chk({name, " addr_in_done"}, addr_w[d], 32'(nb - 1));
            end else begin
                chk({name, " idle_busy"}, {31'h0, busy_w[d]}, 32'h0);
                chk({name, " idle_addr"}, addr_w[d], 32'h0);
                chk({name, " idle_tx"}, {31'h0, tx_w[d]}, 32'h1);
            end
            if (done_w[d] === 1'b1) begin
                done_cnt++;
                done_k = k;
            end
            if (k == abort_at) begin
                rst_s[d] = 1'b1;
                step();
                rst_s[d] = 1'b0;
                chk({name, " rst_tx"}, {31'h0, tx_w[d]}, 32'h1);
                chk({name, " rst_busy"}, {31'h0, busy_w[d]}, 32'h0);
                chk({name, " rst_addr"}, addr_w[d], 32'h0);
                exp_q.delete();
                return;
            end
            if (k == pulse_at) start_s[d] = 1'b1;
            else if (!hold)    start_s[d] = 1'b0;
            if (k < nb * p + 1) step();
        end
        chk({name, " busy_run"}, {31'h0, busy_ok}, 32'h1);
        chk({name, " done_count"}, 32'(done_cnt), 32'h1);
        chk({name, " done_cycle"}, 32'(done_k), 32'(nb * p));
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            start_s[d] = 1'b0;
            rst_s[d]   = 1'b1;
            for (int i = 0; i < 4; i++) mem[d][i] = 8'h00;
        end
        mem[0][0] = 8'hA5;
        mem[1][0] = 8'h00;
        mem[1][1] = 8'hFF;
        mem[1][2] = 8'h3C;
        mem[2][0] = 8'h5A;
        mem[2][1] = 8'hC3;
        mem[3][0] = 8'h80;
        step();
        step();
        for (int d = 0; d < 4; d++) rst_s[d] = 1'b0;
        step();

        // Reset state of every instance
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset_tx%0d", d), {31'h0, tx_w[d]}, 32'h1);
            chk($sformatf("reset_busy%0d", d), {31'h0, busy_w[d]}, 32'h0);
            chk($sformatf("reset_done%0d", d), {31'h0, done_w[d]}, 32'h0);
            chk($sformatf("reset_addr%0d", d), addr_w[d], 32'h0);
        end

        // Single byte 0xA5, done 42 cycles after start accepted
        go(0, 1);
        run_check(0, 4, 1, -1, -1, 1'b0, "t1");

        // Three bytes with exact inter-byte gaps and stepping addresses
        go(1, 3);
        run_check(1, 4, 3, -1, -1, 1'b0, "t2");

        // Start pulsed again during byte 1 is ignored and not queued
        go(1, 3);
        run_check(1, 4, 3, 42 + 10, -1, 1'b0, "t3");
        step();
        chk("t3 no_requeue", {31'h0, busy_w[1]}, 32'h0);

        // Reset during data bits of byte 0, then a fresh run from address 0
        go(1, 3);
        run_check(1, 4, 3, -1, 2 + 3 * 4, 1'b0, "t4a");
        step();
        go(1, 3);
        run_check(1, 4, 3, -1, -1, 1'b0, "t4b");

        // Start held high: second run begins one cycle after done and repeats
        go(2, 2);
        for (int i = 0; i < 2; i++) exp_q.push_back(mem[2][i]);
        run_check(2, 4, 2, -1, -1, 1'b1, "t5a");
        step();
        run_check(2, 4, 2, -1, -1, 1'b0, "t5b");

        // Two-cycle bit periods, MSB-only data
        go(3, 1);
        run_check(3, 2, 1, -1, -1, 1'b0, "t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
